weight_stream_repeater: RTL and testbench
=========================================

Name: weight_stream_repeater

Overview:
- Sits directly downstream of a per-parameter weight source (`*_weight_source`, ROM-backed) and upstream of the linear/matmul compute core.
- Captures one full weight tile, DEPTH beats of PARALLELISM elements each, from the source over a valid/ready stream.
- Replays that tile REPEAT times to the compute core, once per activation row, so the ROM is not re-read for every row.
- Absorbs backpressure from the compute core: beats are never dropped and never duplicated.

Parameters:
- DATA_WIDTH, 16, bits per weight element (matches WEIGHT_PRECISION_0).
- PARALLELISM, 1, elements per beat (WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1).
- DEPTH, 32, beats per tile (OUT_DEPTH of the source); must be >= 1.
- REPEAT, 4, replays of each tile before the next tile is captured; must be >= 1.
- CNT_W, $clog2(DEPTH)+1, width of the beat pointers.
- REP_W, $clog2(REPEAT)+1, width of the pass counter.

Ports:
- clk, input, 1, clock; all state updates on its rising edge.
- rst, input, 1, reset: asynchronous assert, active-low (0 = reset).
- data_in, input, [DATA_WIDTH-1:0] x [PARALLELISM-1:0], weight beat from the source.
- data_in_valid, input, 1, data_in holds a valid beat.
- data_in_ready, output, 1, block accepts data_in this cycle.
- data_out, output, [DATA_WIDTH-1:0] x [PARALLELISM-1:0], replayed beat to the compute core.
- data_out_valid, output, 1, data_out holds a valid beat.
- data_out_ready, input, 1, compute core accepts data_out.
- tile_done, output, 1, single-cycle pulse after the last beat of the last replay is accepted.

Behaviour:
- Reset, rst=0, asynchronous:
  - state=FILL, wr_ptr=0, rd_ptr=0, pass_cnt=0.
  - Registered ready flag=0, so data_in_ready=0.
  - data_out_valid=0, data_out all zero, tile_done=0.
  - Buffer contents are not reset.
- The ready flag sets to 1 on the first rising clk edge after rst goes high.
- State FILL:
  - data_in_ready = ready flag; data_out_valid=0; data_out=0.
  - Input handshake is data_in_valid && data_in_ready. On each handshake: buf[wr_ptr] <= data_in, then wr_ptr++.
  - On the handshake where wr_ptr==DEPTH-1: wr_ptr<=0 and state<=REPLAY.
  - data_in_ready is 0 in the cycle after that final handshake, so no extra beat is taken.
- State REPLAY:
  - data_in_ready=0; data_out_valid=1; data_out=buf[rd_ptr], read combinationally from the register array.
  - Output handshake is data_out_valid && data_out_ready. On each handshake rd_ptr++.
  - If rd_ptr==DEPTH-1: rd_ptr<=0.
    - If pass_cnt==REPEAT-1: pass_cnt<=0, state<=FILL, tile_done<=1 for exactly one cycle.
    - Otherwise pass_cnt++.
  - data_out_ready=0 holds data_out and all pointers stable for any number of cycles (AXI-style stability).
- Latency:
  - The first replayed beat is valid in the cycle after the last fill handshake.
  - The next fill can be accepted from the cycle after the final replay handshake. In that cycle tile_done=1 and data_in_ready=1.
  - A tile therefore costs DEPTH input cycles plus DEPTH*REPEAT output cycles minimum, with no bubbles inside a phase.
- Boundaries:
  - DEPTH=1: one accept, then REPEAT outputs.
  - REPEAT=1: plain store-and-forward.
  - Both =1: alternate accept/emit every cycle.
- data_in_valid with data_in_ready=0 (REPLAY, or the first cycle after reset) is ignored; the source must hold the beat.
- rst asserted mid-FILL or mid-REPLAY aborts immediately to the reset state. The partial tile is discarded, and the next tile starts at wr_ptr=0.
- Element order within a beat is preserved: data_out[j] equals the data_in[j] captured for that beat.
- Parameter checks: elaboration error if DEPTH<1 or REPEAT<1.

Test Plan:
- Basic, DEPTH=4, REPEAT=2, PARALLELISM=2, ready always 1:
  - Stimulus: feed beats {1,2},{3,4},{5,6},{7,8}.
  - Required: data_out sequence is {1,2},{3,4},{5,6},{7,8} twice, with no gaps.
  - Required: tile_done pulses once, in the cycle after the 8th output handshake.
  - Required: data_in_ready=1 in that same cycle.
- Backpressure:
  - Stimulus: same tile; toggle data_out_ready 1,0,0,1,... randomly.
  - Required: the output stream is identical to the basic case, and data_out is stable in every stall cycle.
- Input gaps:
  - Stimulus: data_in_valid asserted every 3rd cycle with beats 10,20,30,40 (PARALLELISM=1).
  - Required: all 4 captured in order, and REPLAY entered only after the 4th.
- Reset mid-operation:
  - Stimulus: assert rst after 2 of 4 fill beats, or after 5 replay beats; release; feed a new tile 100..103.
  - Required: outputs are only 100..103 ×REPEAT, with no stale beat.
  - Required: data_in_ready=0 until the first edge after release.
- Degenerate, DEPTH=1, REPEAT=1:
  - Stimulus: 6 beats 0xA..0xF with valid and ready both constantly 1.
  - Required: the output equals the input, delayed one cycle, alternating accept/emit.
  - Required: 6 tile_done pulses.
- Back-to-back tiles, DEPTH=32, REPEAT=4, fed by a *_weight_source model:
  - Required: 3 tiles yield 3×128 output beats matching the ROM image, in order.
  - Required: exactly 3 tile_done pulses.

Source files
------------

// File: rtl/weight_stream_repeater.sv
// rtl/weight_stream_repeater.sv - captures one weight tile and replays it REPEAT times downstream
module weight_stream_repeater #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARALLELISM = 1,
    parameter int DEPTH       = 32,
    parameter int REPEAT      = 4,
    parameter int CNT_W       = $clog2(DEPTH) + 1,
    parameter int REP_W       = $clog2(REPEAT) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in [PARALLELISM-1:0],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [PARALLELISM-1:0],
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  tile_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);
    localparam logic [REP_W-1:0] LAST_PASS = REP_W'(REPEAT - 1);

    if (DEPTH < 1) begin : g_bad_depth
        $error("weight_stream_repeater: DEPTH must be >= 1");
    end
    if (REPEAT < 1) begin : g_bad_repeat
        $error("weight_stream_repeater: REPEAT must be >= 1");
    end

    typedef enum logic {
        S_FILL   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [REP_W-1:0] pass_cnt_q, pass_cnt_d;
    logic             rdy_flag_q, rdy_flag_d;
    logic             tile_done_q, tile_done_d;
    logic             mem_wr_en;

    // Tile buffer is deliberately left out of reset; pointers alone define validity.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH][PARALLELISM];

    logic          in_hs;
    logic          out_hs;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign in_hs  = data_in_valid && data_in_ready;
    assign out_hs = data_out_valid && data_out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pass_cnt_q  <= '0;
            rdy_flag_q  <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pass_cnt_q  <= pass_cnt_d;
            rdy_flag_q  <= rdy_flag_d;
            tile_done_q <= tile_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            for (int j = 0; j < PARALLELISM; j++) begin
                mem_q[wr_idx][j] <= data_in[j];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pass_cnt_d  = pass_cnt_q;
        rdy_flag_d  = 1'b1;
        tile_done_d = 1'b0;
        mem_wr_en   = 1'b0;
        case (state_q)
            S_FILL: begin
                if (in_hs) begin
                    mem_wr_en = 1'b1;
                    if (wr_ptr_q == LAST_BEAT) begin
                        wr_ptr_d = '0;
                        state_d  = S_REPLAY;
                    end else begin
                        wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    end
                end
            end
            S_REPLAY: begin
                if (out_hs) begin
                    if (rd_ptr_q == LAST_BEAT) begin
                        rd_ptr_d = '0;
                        if (pass_cnt_q == LAST_PASS) begin
                            pass_cnt_d  = '0;
                            state_d     = S_FILL;
                            tile_done_d = 1'b1;
                        end else begin
                            pass_cnt_d = pass_cnt_q + REP_W'(1);
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Replay data is read straight from the register array so stalls cost nothing.
    always_comb begin
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        tile_done      = tile_done_q;
        for (int j = 0; j < PARALLELISM; j++) begin
            data_out[j] = '0;
        end
        case (state_q)
            S_FILL: begin
                data_in_ready = rdy_flag_q;
            end
            S_REPLAY: begin
                data_out_valid = 1'b1;
                for (int j = 0; j < PARALLELISM; j++) begin
                    data_out[j] = mem_q[rd_idx][j];
                end
            end
            default: data_in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_weight_stream_repeater.sv
// tb/tb_weight_stream_repeater.sv - directed and randomized checks of weight_stream_repeater
module tb_weight_stream_repeater;

    typedef logic [31:0] q32_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        din_valid;
    logic        dout_ready;
    logic        rnd_ready;
    int          sel;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    // A: D4 R2 P2, B: D1 R1 P1, C: D32 R4 P1, D: D4 R2 P1
    logic [15:0] a_in [2], a_out [2];
    logic [15:0] b_in [1], b_out [1];
    logic [15:0] c_in [1], c_out [1];
    logic [15:0] d_in [1], d_out [1];
    logic a_ird, a_ov, a_td, b_ird, b_ov, b_td, c_ird, c_ov, c_td, d_ird, d_ov, d_td;
    logic va, vb, vc, vd;

    assign a_in[0] = din[15:0];
    assign a_in[1] = din[31:16];
    assign b_in[0] = din[15:0];
    assign c_in[0] = din[15:0];
    assign d_in[0] = din[15:0];
    assign va = din_valid && (sel == 0);
    assign vb = din_valid && (sel == 1);
    assign vc = din_valid && (sel == 2);
    assign vd = din_valid && (sel == 3);

    weight_stream_repeater #(.DATA_WIDTH(16), .PARALLELISM(2), .DEPTH(4), .REPEAT(2)) u_a (
        .clk(clk), .rst(rst_n), .data_in(a_in), .data_in_valid(va), .data_in_ready(a_ird),
        .data_out(a_out), .data_out_valid(a_ov), .data_out_ready(dout_ready), .tile_done(a_td));
    weight_stream_repeater #(.DATA_WIDTH(16), .PARALLELISM(1), .DEPTH(1), .REPEAT(1)) u_b (
        .clk(clk), .rst(rst_n), .data_in(b_in), .data_in_valid(vb), .data_in_ready(b_ird),
        .data_out(b_out), .data_out_valid(b_ov), .data_out_ready(dout_ready), .tile_done(b_td));
    weight_stream_repeater #(.DATA_WIDTH(16), .PARALLELISM(1), .DEPTH(32), .REPEAT(4)) u_c (
        .clk(clk), .rst(rst_n), .data_in(c_in), .data_in_valid(vc), .data_in_ready(c_ird),
        .data_out(c_out), .data_out_valid(c_ov), .data_out_ready(dout_ready), .tile_done(c_td));
    weight_stream_repeater #(.DATA_WIDTH(16), .PARALLELISM(1), .DEPTH(4), .REPEAT(2)) u_d (
        .clk(clk), .rst(rst_n), .data_in(d_in), .data_in_valid(vd), .data_in_ready(d_ird),
        .data_out(d_out), .data_out_valid(d_ov), .data_out_ready(dout_ready), .tile_done(d_td));

    logic [31:0] m_data;
    logic        m_ird, m_ov, m_td;
    always_comb begin
        m_data = {a_out[1], a_out[0]};
        m_ird  = a_ird;
        m_ov   = a_ov;
        m_td   = a_td;
        case (sel)
            1: begin m_data = {16'h0, b_out[0]}; m_ird = b_ird; m_ov = b_ov; m_td = b_td; end
            2: begin m_data = {16'h0, c_out[0]}; m_ird = c_ird; m_ov = c_ov; m_td = c_td; end
            3: begin m_data = {16'h0, d_out[0]}; m_ird = d_ird; m_ov = d_ov; m_td = d_td; end
            default: ;
        endcase
    end

    // Passive recorder of handshakes on the selected instance
    int          cyc = 0;
    logic [31:0] out_q[$];
    int          out_cyc[$], in_cyc[$], done_cyc[$];
    logic        done_rdy[$];
    int          stall_err = 0;
    int          stall_seen = 0;
    logic        p_stall = 1'b0;
    logic [31:0] p_data;

    always @(negedge clk) begin
        cyc++;
        if (p_stall && !(m_ov && m_data === p_data)) stall_err++;
        p_stall = m_ov && !dout_ready;
        if (p_stall) stall_seen++;
        p_data  = m_data;
        if (m_ov && dout_ready) begin
            out_q.push_back(m_data);
            out_cyc.push_back(cyc);
        end
        if (din_valid && m_ird) in_cyc.push_back(cyc);
        if (m_td) begin
            done_cyc.push_back(cyc);
            done_rdy.push_back(m_ird);
        end
    end

    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        out_q.delete();
        out_cyc.delete();
        in_cyc.delete();
        done_cyc.delete();
        done_rdy.delete();
        stall_err  = 0;
        stall_seen = 0;
        p_stall    = 1'b0;
    endtask

    // Each tile of depth beats is emitted rep times before the next tile
    function automatic q32_t model(input q32_t beats, input int depth, input int rep);
        q32_t r;
        for (int t = 0; t < beats.size() / depth; t++)
            for (int p = 0; p < rep; p++)
                for (int i = 0; i < depth; i++)
                    r.push_back(beats[t * depth + i]);
        return r;
    endfunction

    task automatic feed(input q32_t beats, input int max_gap, input bit rnd_gap);
        foreach (beats[i]) begin
            int g;
            int n;
            g = rnd_gap ? $urandom_range(max_gap, 0) : max_gap;
            din_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            din       = beats[i];
            din_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!m_ird && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (!m_ird) begin
                check("feed_timeout", 32'(m_ird), 32'd1);
                din_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_wait_timeout", 32'(done_cyc.size() >= n), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic cmp_stream(input string tag, input q32_t exp);
        check({tag, "_count"}, 32'(out_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), out_q[i], exp[i]);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(m_ov), 32'd0);
        check("rst_async_ready", 32'(m_ird), 32'd0);
        check("rst_async_data", m_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_low_before_edge", 32'(m_ird), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        q32_t tile, tile2, rom;
        int   w;
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        sel       = 0;
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(m_ird), 32'd0);
        check("reset_out_valid", 32'(m_ov), 32'd0);
        check("reset_data_out", m_data, 32'd0);
        check("reset_tile_done", 32'(m_td), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_first_cycle", 32'(m_ird), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(m_ird), 32'd1);

        // Basic: 4 beats of 2 elements, replayed twice, no stalls
        clear();
        tile = {32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
        feed(tile, 0, 1'b0);
        wait_done(1, 200);
        cmp_stream("basic", model(tile, 4, 2));
        check("basic_done_count", 32'(done_cyc.size()), 32'd1);
        if (out_q.size() == 8 && in_cyc.size() == 4 && done_cyc.size() >= 1) begin
            check("basic_first_latency", 32'(out_cyc[0] - in_cyc[3]), 32'd1);
            for (int i = 0; i < 7; i++)
                check($sformatf("basic_nogap%0d", i), 32'(out_cyc[i + 1] - out_cyc[i]), 32'd1);
            check("basic_done_timing", 32'(done_cyc[0] - out_cyc[7]), 32'd1);
            check("basic_done_ready", 32'(done_rdy[0]), 32'd1);
        end

        // Backpressure: random data_out_ready, identical stream, stable while stalled
        clear();
        rnd_ready = 1'b1;
        feed(tile, 0, 1'b0);
        wait_done(1, 500);
        rnd_ready = 1'b0;
        cmp_stream("bp", model(tile, 4, 2));
        check("bp_stall_stable", 32'(stall_err), 32'd0);
        check("bp_done_count", 32'(done_cyc.size()), 32'd1);

        // Input gaps: valid every third cycle
        sel = 3;
        clear();
        tile = {32'd10, 32'd20, 32'd30, 32'd40};
        feed(tile, 2, 1'b0);
        wait_done(1, 200);
        cmp_stream("gaps", model(tile, 4, 2));
        if (in_cyc.size() == 4 && out_cyc.size() >= 1) begin
            check("gaps_spacing", 32'(in_cyc[3] - in_cyc[0]), 32'd9);
            check("gaps_replay_after_4th", 32'(out_cyc[0] - in_cyc[3]), 32'd1);
        end

        // Reset after two fill beats
        clear();
        tile = {32'd7, 32'd8};
        feed(tile, 0, 1'b0);
        reset_pulse();
        clear();
        tile2 = {32'd100, 32'd101, 32'd102, 32'd103};
        feed(tile2, 0, 1'b0);
        wait_done(1, 200);
        cmp_stream("rst_fill", model(tile2, 4, 2));

        // Reset after five replay beats
        clear();
        tile = {32'd50, 32'd51, 32'd52, 32'd53};
        feed(tile, 0, 1'b0);
        w = 0;
        while (out_q.size() < 5 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rst_replay_reach5", 32'(out_q.size()), 32'd5);
        @(posedge clk);
        #1;
        reset_pulse();
        clear();
        feed(tile2, 0, 1'b0);
        wait_done(1, 200);
        cmp_stream("rst_replay", model(tile2, 4, 2));

        // Degenerate DEPTH=1 REPEAT=1: alternate accept and emit
        sel = 1;
        clear();
        tile = {32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
        feed(tile, 0, 1'b0);
        wait_done(6, 200);
        cmp_stream("degen", model(tile, 1, 1));
        check("degen_done_count", 32'(done_cyc.size()), 32'd6);
        if (in_cyc.size() == 6 && out_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++)
                check($sformatf("degen_delay%0d", i), 32'(out_cyc[i] - in_cyc[i]), 32'd1);
            for (int i = 0; i < 5; i++)
                check($sformatf("degen_alt%0d", i), 32'(in_cyc[i + 1] - out_cyc[i]), 32'd1);
        end

        // Three back-to-back tiles from a ROM image, random gaps and stalls
        sel = 2;
        clear();
        rom = {};
        for (int i = 0; i < 96; i++) rom.push_back(32'($urandom_range(16'hFFFF, 0)));
        rnd_ready = 1'b1;
        feed(rom, 2, 1'b1);
        wait_done(3, 5000);
        rnd_ready = 1'b0;
        cmp_stream("rom", model(rom, 32, 4));
        check("rom_done_count", 32'(done_cyc.size()), 32'd3);
        check("rom_stall_stable", 32'(stall_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
